// File: rtl/fft_r4_twiddle_sequencer.sv
// Radix-4 DIF FFT address sequencer: per beat emits sample address and twiddle exponent, stage by stage.
// Latency: first beat registered one cycle after start is taken; DRAIN_CYC idle cycles between stages.
// Backpressure: outputs hold while out_ready_i=0. Optional tw_unity_o port under FFT_TW_UNITY_EN.
module fft_r4_twiddle_sequencer #(
    parameter int LOG4N     = 3,
    parameter int DRAIN_CYC = 4,
    parameter int STW       = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [STW-1:0]       stage_o,
    output logic [2*LOG4N-1:0]   samp_addr_o,
    output logic [2*LOG4N-1:0]   tw_addr_o,
    output logic                 last_in_stage_o
`ifdef FFT_TW_UNITY_EN
    ,
    output logic                 tw_unity_o
`endif
);

    localparam int AW = 2 * LOG4N;
    localparam int N  = 1 << AW;
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   c_q, c_d;
    logic [STW-1:0]  s_q, s_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            vld_q, vld_d;
    logic [AW-1:0]   samp_q, samp_d;
    logic [AW-1:0]   tw_q, tw_d;
    logic            last_q, last_d;
    logic            load;

    // Sample address swaps the q digit (c[1:0]) above the j field: c = {g,j,q} -> {g,q,j}.
    function automatic logic [AW-1:0] samp_of(input logic [AW-1:0] c, input logic [STW-1:0] s);
        logic [AW-1:0] r;
        int            jw;
        r = c;
        for (int k = 0; k < LOG4N; k++) begin
            if (s == STW'(k)) begin
                jw = 2 * (LOG4N - 1 - k);
                r  = ((c >> (jw + 2)) << (jw + 2))
                   | (AW'(c[1:0]) << jw)
                   | ((c >> 2) & ((AW'(1) << jw) - AW'(1)));
            end
        end
        return r;
    endfunction

    // Twiddle exponent q*j scaled by 4^s; AW-bit arithmetic gives the mod-N wrap for free.
    function automatic logic [AW-1:0] tw_of(input logic [AW-1:0] c, input logic [STW-1:0] s);
        logic [AW-1:0] r;
        logic [AW-1:0] j;
        int            jw;
        r = '0;
        for (int k = 0; k < LOG4N; k++) begin
            if (s == STW'(k)) begin
                jw = 2 * (LOG4N - 1 - k);
                j  = (c >> 2) & ((AW'(1) << jw) - AW'(1));
                r  = (AW'(c[1:0]) * j) << (2 * k);
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        s_d     = s_q;
        drain_d = drain_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        vld_d   = vld_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                vld_d  = 1'b0;
                if (start_i) begin
                    state_d = S_RUN;
                    c_d     = '0;
                    s_d     = '0;
                    busy_d  = 1'b1;
                    vld_d   = 1'b1;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (out_ready_i) begin
                    if (c_q == AW'(N - 1)) begin
                        c_d = '0;
                        if (DRAIN_CYC == 0) begin
                            if (s_q == STW'(LOG4N - 1)) begin
                                state_d = S_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                vld_d   = 1'b0;
                            end else begin
                                s_d  = s_q + STW'(1);
                                load = 1'b1;
                            end
                        end else begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                            vld_d   = 1'b0;
                        end
                    end else begin
                        c_d  = c_q + AW'(1);
                        load = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DRAIN_CYC - 1)) begin
                    if (s_q == STW'(LOG4N - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        s_d     = s_q + STW'(1);
                        vld_d   = 1'b1;
                        load    = 1'b1;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        samp_d = load ? samp_of(c_d, s_d) : samp_q;
        tw_d   = load ? tw_of(c_d, s_d) : tw_q;
        last_d = load ? (c_d == AW'(N - 1)) : last_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            s_q     <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            samp_q  <= '0;
            tw_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            s_q     <= s_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            samp_q  <= samp_d;
            tw_q    <= tw_d;
            last_q  <= last_d;
        end
    end

`ifdef FFT_TW_UNITY_EN
    logic unity_q, unity_d;

    always_comb begin
        unity_d = unity_q;
        if (load) unity_d = (tw_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) unity_q <= 1'b0;
        else         unity_q <= unity_d;
    end

    assign tw_unity_o = unity_q;
`endif

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign out_valid_o     = vld_q;
    assign stage_o         = s_q;
    assign samp_addr_o     = samp_q;
    assign tw_addr_o       = tw_q;
    assign last_in_stage_o = last_q;

endmodule
